key_conditioner: RTL and testbench

- Multi-channel push-button conditioner directly upstream of the game and piano cores; sits between board pins and the move/key inputs.
- Per channel: synchronises the raw button, debounces it, and produces a clean level plus one-cycle press and release pulses.
- With the optional feature compiled in, it also produces a held-key auto-repeat pulse train for paddle movement.
- Channels are fully independent; one instance covers the 3-key move group.

---
 rtl/key_conditioner.sv | 169 ++++++++++++++++
 tb/tb_key_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: 2-flop sync, debounce FSM, press/release pulses.
// Define KEY_AUTO_REPEAT_EN to add a held-key auto-repeat pulse train on key_repeat.
module key_conditioner #(
   parameter int N_KEYS       = 3,
   parameter int ACTIVE_LOW   = 1,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int REPEAT_DLY   = 25000000,
   parameter int REPEAT_PER   = 5000000
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   localparam int            CW      = $clog2(DEBOUNCE_CYC);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic          REL_VAL = (ACTIVE_LOW != 0);

`ifdef KEY_AUTO_REPEAT_EN
   localparam int            RMAX     = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int            RW       = $clog2(RMAX);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);
`endif

   typedef enum logic [1:0] {
      UP,
      PRESS_CHK,
      DOWN,
      REL_CHK
   } state_t;

   if (DEBOUNCE_CYC < 2 || REPEAT_DLY < 2 || REPEAT_PER < 2) begin : g_param_check
      $error("key_conditioner: DEBOUNCE_CYC, REPEAT_DLY and REPEAT_PER must each be at least 2");
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      logic          sync_a;
      logic          sync_b;
      logic          p;
      state_t        state;
      logic [CW-1:0] cnt;
      logic          level_q;
      logic          press_q;
      logic          release_q;
      logic          accept_press;
      logic          accept_release;

      // Synchroniser resets to the released level so reset never looks like a press
      always_ff @(posedge sys_clk) begin
         if (!rst_n) begin
            sync_a <= REL_VAL;
            sync_b <= REL_VAL;
         end else begin
            sync_a <= key_in[i];
            sync_b <= sync_a;
         end
      end

      assign p              = sync_b ^ REL_VAL;
      assign accept_press   = (state == PRESS_CHK) && p && (cnt == DB_LAST);
      assign accept_release = (state == REL_CHK) && !p && (cnt == DB_LAST);

      // Debounce FSM: a change is accepted only after DEBOUNCE_CYC consecutive agreeing samples
      always_ff @(posedge sys_clk) begin
         if (!rst_n) begin
            state     <= UP;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
               UP: begin
                  level_q <= 1'b0;
                  if (p) begin
                     state <= PRESS_CHK;
                     cnt   <= CW'(1);
                  end
               end
               PRESS_CHK: begin
                  if (!p) begin
                     state <= UP;
                     cnt   <= '0;
                  end else if (accept_press) begin
                     state   <= DOWN;
                     cnt     <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DOWN: begin
                  level_q <= 1'b1;
                  if (!p) begin
                     state <= REL_CHK;
                     cnt   <= CW'(1);
                  end
               end
               REL_CHK: begin
                  if (p) begin
                     state <= DOWN;
                     cnt   <= '0;
                  end else if (accept_release) begin
                     state     <= UP;
                     cnt       <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= UP;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;

`ifdef KEY_AUTO_REPEAT_EN
      logic          rep_q;
      logic          rep_armed;
      logic [RW-1:0] rcnt;

      // Repeat timer survives release bounces; a release accepted this cycle wins over a repeat
      always_ff @(posedge sys_clk) begin
         if (!rst_n) begin
            rep_q     <= 1'b0;
            rep_armed <= 1'b0;
            rcnt      <= '0;
         end else begin
            rep_q <= 1'b0;
            if (accept_press) begin
               rcnt      <= '0;
               rep_armed <= 1'b0;
            end else if ((state == DOWN || state == REL_CHK) && !accept_release) begin
               if (rcnt == (rep_armed ? PER_LAST : DLY_LAST)) begin
                  rep_q     <= 1'b1;
                  rcnt      <= '0;
                  rep_armed <= 1'b1;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end else begin
               rcnt      <= '0;
               rep_armed <= 1'b0;
            end
         end
      end

      assign key_repeat[i] = rep_q;
`else
      assign key_repeat[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner (DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3).
module tb_key_conditioner;

   localparam int N_KEYS       = 3;
   localparam int DEBOUNCE_CYC = 4;
   localparam int REPEAT_DLY   = 10;
   localparam int REPEAT_PER   = 3;
`ifdef KEY_AUTO_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic              sys_clk = 1'b0;
   logic              rst_n;
   logic [N_KEYS-1:0] key_in;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_press;
   logic [N_KEYS-1:0] key_release;
   logic [N_KEYS-1:0] key_repeat;

   int checks   = 0;
   int failures = 0;
   int press_cnt[N_KEYS]   = '{0, 0, 0};
   int release_cnt[N_KEYS] = '{0, 0, 0};
   int repeat_cnt[N_KEYS]  = '{0, 0, 0};
   int overlap_cnt         = 0;

   key_conditioner #(
      .N_KEYS       (N_KEYS),
      .ACTIVE_LOW   (1),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
   ) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_repeat  (key_repeat)
   );

   always #5 sys_clk = ~sys_clk;

   // Pulse tallies taken mid-cycle, used for whole-run totals
   always @(negedge sys_clk) begin
      for (int i = 0; i < N_KEYS; i++) begin
         if (key_press[i] === 1'b1) press_cnt[i]++;
         if (key_release[i] === 1'b1) release_cnt[i]++;
         if (key_repeat[i] === 1'b1) repeat_cnt[i]++;
         if (key_press[i] === 1'b1 && key_release[i] === 1'b1) overlap_cnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [N_KEYS-1:0] keys, input int cycles);
      key_in = keys;
      repeat (cycles) tick();
   endtask

   initial begin
      logic [N_KEYS-1:0] exp_rep;

      // Reset with all keys held down
      rst_n  = 1'b0;
      key_in = 3'b000;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("reset_outputs", {key_level, key_press, key_release, key_repeat}, 32'h0);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput("post_reset_press_early", key_press, 3'b000);
      end
      tick();
      checkOutput("post_reset_press", key_press, 3'b111);
      checkOutput("post_reset_level", key_level, 3'b111);
      tick();
      checkOutput("post_reset_press_single", key_press, 3'b000);
      checkOutput("post_reset_level_hold", key_level, 3'b111);

      key_in = 3'b111;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput("all_release_early", key_release, 3'b000);
         checkOutput("all_release_level_hold", key_level, 3'b111);
      end
      tick();
      checkOutput("all_release_pulse", key_release, 3'b111);
      checkOutput("all_release_level", key_level, 3'b000);
      tick();
      checkOutput("all_release_single", key_release, 3'b000);
      applyStimulus(3'b111, 3);

      // Clean press on channel 0, then hold for the repeat train
      key_in = 3'b110;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput("ch0_press_early", key_press, 3'b000);
      end
      tick();
      checkOutput("ch0_press", key_press, 3'b001);
      checkOutput("ch0_level", key_level, 3'b001);
      for (int k = 1; k <= 30; k++) begin
         tick();
         exp_rep = 3'b000;
         if (REP_ON && k >= REPEAT_DLY && ((k - REPEAT_DLY) % REPEAT_PER) == 0) exp_rep = 3'b001;
         checkOutput($sformatf("ch0_repeat_k%0d", k), key_repeat, exp_rep);
         checkOutput("ch0_hold_level", {key_level, key_press}, {3'b001, 3'b000});
      end

      // Reset while channel 0 is held down
      rst_n = 1'b0;
      tick();
      checkOutput("midhold_reset_outputs", {key_level, key_press, key_release, key_repeat}, 32'h0);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput("reaccept_early", {key_level, key_press, key_release}, 32'h0);
      end
      tick();
      checkOutput("reaccept_press", key_press, 3'b001);
      checkOutput("reaccept_level", key_level, 3'b001);
      tick();
      applyStimulus(3'b111, 9);
      checkOutput("ch0_released_level", key_level, 3'b000);

      // Glitch on channel 1, one sample short of acceptance
      key_in = 3'b101;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checkOutput("glitch_low", {key_level, key_press, key_release}, 32'h0);
      end
      key_in = 3'b111;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checkOutput("glitch_after", {key_level, key_press, key_release}, 32'h0);
      end

      // Release bounce on channel 2
      applyStimulus(3'b011, 8);
      checkOutput("ch2_pressed_level", key_level, 3'b100);
      key_in = 3'b111;
      tick();
      checkOutput("bounce_level_a", key_level, 3'b100);
      tick();
      checkOutput("bounce_level_b", key_level, 3'b100);
      key_in = 3'b011;
      tick();
      checkOutput("bounce_level_c", key_level, 3'b100);
      key_in = 3'b111;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput("bounce_release_early", key_release, 3'b000);
         checkOutput("bounce_level_hold", key_level, 3'b100);
         exp_rep = (REP_ON && k == 5) ? 3'b100 : 3'b000;
         checkOutput("bounce_repeat", key_repeat, exp_rep);
      end
      tick();
      checkOutput("bounce_release_pulse", key_release, 3'b100);
      checkOutput("bounce_release_level", key_level, 3'b000);
      checkOutput("bounce_release_no_repeat", key_repeat, 3'b000);
      tick();
      checkOutput("bounce_release_single", key_release, 3'b000);
      tick();

      // Whole-run pulse totals
      checkOutput("total_press_ch0", press_cnt[0], 3);
      checkOutput("total_press_ch1", press_cnt[1], 1);
      checkOutput("total_press_ch2", press_cnt[2], 2);
      checkOutput("total_release_ch0", release_cnt[0], 2);
      checkOutput("total_release_ch1", release_cnt[1], 1);
      checkOutput("total_release_ch2", release_cnt[2], 2);
      checkOutput("total_repeat_ch0", repeat_cnt[0], REP_ON ? 7 : 0);
      checkOutput("total_repeat_ch1", repeat_cnt[1], 0);
      checkOutput("total_repeat_ch2", repeat_cnt[2], REP_ON ? 1 : 0);
      checkOutput("press_release_overlap", overlap_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
